// File: rtl/cache_data_port.sv
// cache_data_port
//   Access sequencer in front of the 64x128 single-port cache data SRAM
//   (SRAM1RW64x128). It is the only driver of that SRAM and runs one
//   operation at a time.
//   - CPU word read : select line, sample word, respond.
//   - CPU word write: read-modify-write of the whole line, respond with the
//                     word as written.
//   - Memory refill : single line write, no response.
//   A refill wins over a CPU request presented in the same IDLE cycle.
//
// Ports
//   clk, rst_n                     clock (also SRAM CE), async active-low reset
//   req_valid/req_ready            CPU request handshake
//   req_we, req_index, req_word    write flag, line index, word select
//   req_wdata                      CPU write data
//   req_be                         byte enables (only with the macro below)
//   rsp_valid, rsp_rdata           one-cycle completion pulse and its word
//   fill_valid/fill_ready          refill handshake
//   fill_index, fill_data          refill line index and data
//   sram_a/csb/web/oeb/i, sram_o   SRAM pins (control pins active low)
//
// Build option
//   CACHE_DATA_PORT_BYTE_MASK_EN   adds req_be; a write replaces only the
//                                  enabled bytes of the selected word.
module cache_data_port #(
    parameter int ADDR_W = 6,
    parameter int LINE_W = 128,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_index,
    input  logic [1:0]        req_word,
    input  logic [WORD_W-1:0] req_wdata,
`ifdef CACHE_DATA_PORT_BYTE_MASK_EN
    input  logic [3:0]        req_be,
`endif
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [ADDR_W-1:0] fill_index,
    input  logic [LINE_W-1:0] fill_data,
    output logic [ADDR_W-1:0] sram_a,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [LINE_W-1:0] sram_i,
    input  logic [LINE_W-1:0] sram_o
);

    localparam int NB    = WORD_W / 8;
    localparam int OFF_W = $clog2(LINE_W);
    localparam int WSH_W = $clog2(WORD_W);

    typedef enum logic [2:0] {
        IDLE, RD_SEL, RD_DAT, WR_SEL, WR_DAT, WR_WR, FILL_WR, RSP
    } state_t;

    state_t state, state_nxt;

    logic              req_fire, fill_fire;
    logic [1:0]        word_q;
    logic [WORD_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic [OFF_W-1:0]  word_off;
    logic [WORD_W-1:0] rd_word, merged_word, wr_word;
    logic [LINE_W-1:0] merged_line;

    // Readies are held low while reset is asserted, so nothing can be
    // accepted during reset even though the state already reads IDLE.
    assign fill_ready = rst_n & (state == IDLE);
    assign req_ready  = fill_ready & ~fill_valid;
    assign req_fire   = req_valid & req_ready;
    assign fill_fire  = fill_valid & fill_ready;

    // Bit offset of the selected word inside the line.
    assign word_off = OFF_W'({word_q, {WSH_W{1'b0}}});
    assign rd_word  = sram_o[word_off +: WORD_W];
    assign wr_word  = sram_i[word_off +: WORD_W];

    // Byte-lane merge of the write data over the word just read.
    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign merged_word[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : rd_word[8*b +: 8];
    end

    always_comb begin
        merged_line                        = sram_o;
        merged_line[word_off +: WORD_W]    = merged_word;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and SRAM control decode (state only, never from inputs)
    always_comb begin
        state_nxt = state;
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_oeb  = 1'b1;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (fill_fire)     state_nxt = FILL_WR;
                else if (req_fire) state_nxt = req_we ? WR_SEL : RD_SEL;
            end
            RD_SEL: begin
                sram_csb  = 1'b0;
                state_nxt = RD_DAT;
            end
            RD_DAT: begin
                sram_oeb  = 1'b0;
                state_nxt = RSP;
            end
            WR_SEL: begin
                sram_csb  = 1'b0;
                state_nxt = WR_DAT;
            end
            WR_DAT: begin
                sram_oeb  = 1'b0;
                state_nxt = WR_WR;
            end
            WR_WR: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                state_nxt = RSP;
            end
            FILL_WR: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                state_nxt = IDLE;
            end
            RSP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Captured request / line registers. sram_a and sram_i are these
    // registers directly, so they hold their last value between uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a    <= '0;
            sram_i    <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
        end else begin
            if (fill_fire) begin
                sram_a <= fill_index;
                sram_i <= fill_data;
            end else if (req_fire) begin
                sram_a  <= req_index;
                word_q  <= req_word;
                wdata_q <= req_wdata;
            end
            if (state == WR_DAT) sram_i <= merged_line;
            // rsp_rdata changes only on the edge into RSP.
            if (state == RD_DAT) rsp_rdata <= rd_word;
            if (state == WR_WR)  rsp_rdata <= wr_word;
        end
    end

`ifdef CACHE_DATA_PORT_BYTE_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        be_q <= '1;
        else if (req_fire) be_q <= req_be;
    end
`else
    assign be_q = '1;
`endif

endmodule

// File: tb/tb_cache_data_port.sv
// tb_cache_data_port
//   Directed bench for cache_data_port with a behavioural 64x128 SRAM.
//   Inputs are driven and outputs sampled around the falling clock edge.
//   Define CACHE_DATA_PORT_BYTE_MASK_EN to also cover byte-masked writes.
module tb_cache_data_port;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [5:0]   req_index = '0;
    logic [1:0]   req_word = '0;
    logic [31:0]  req_wdata = '0;
`ifdef CACHE_DATA_PORT_BYTE_MASK_EN
    logic [3:0]   req_be = 4'hF;
`endif
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         fill_valid = 1'b0;
    logic         fill_ready;
    logic [5:0]   fill_index = '0;
    logic [127:0] fill_data = '0;
    logic [5:0]   sram_a;
    logic         sram_csb, sram_web, sram_oeb;
    logic [127:0] sram_i, sram_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_data_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_index  (req_index),
        .req_word   (req_word),
        .req_wdata  (req_wdata),
`ifdef CACHE_DATA_PORT_BYTE_MASK_EN
        .req_be     (req_be),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_index (fill_index),
        .fill_data  (fill_data),
        .sram_a     (sram_a),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_oeb   (sram_oeb),
        .sram_i     (sram_i),
        .sram_o     (sram_o)
    );

    // Behavioural SRAM: synchronous select, data on O the next cycle.
    logic [127:0] mem [64];
    logic [127:0] dout = '0;
    int           wr_cnt = 0;
    logic [5:0]   last_a = '0;
    logic [127:0] last_i = '0;

    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                mem[sram_a] <= sram_i;
                wr_cnt      <= wr_cnt + 1;
                last_a      <= sram_a;
                last_i      <= sram_i;
            end else begin
                dout <= mem[sram_a];
            end
        end
    end
    assign sram_o = sram_oeb ? '0 : dout;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge of T+1; ends at a falling edge in IDLE.
    task automatic wait_rsp(input string tag, input int lat, input logic [31:0] exp);
        int n = 1;
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(lat));
        chk({tag, "_data"}, 128'(rsp_rdata), 128'(exp));
        @(negedge clk);
        #1;
        chk({tag, "_idle"}, {126'd0, rsp_valid, req_ready}, 128'b01);
    endtask

    task automatic do_fill(input string tag, input logic [5:0] idx, input logic [127:0] data);
        fill_valid = 1'b1;
        fill_index = idx;
        fill_data  = data;
        #1;
        chk({tag, "_rdy"}, 128'(fill_ready), 128'd1);
        @(negedge clk);
        fill_valid = 1'b0;
        #1;
        chk({tag, "_wr"}, {sram_csb, sram_web, 6'd0, sram_a, sram_i[111:0]},
            {1'b0, 1'b0, 6'd0, idx, data[111:0]});
        @(negedge clk);
        #1;
        chk({tag, "_idle"}, {125'd0, sram_csb, sram_web, req_ready}, 128'b111);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [5:0] idx,
                          input logic [1:0] word, input logic [31:0] wdata,
                          input logic [31:0] exp);
        req_valid = 1'b1;
        req_we    = we;
        req_index = idx;
        req_word  = word;
        req_wdata = wdata;
        #1;
        chk({tag, "_rdy"}, 128'(req_ready), 128'd1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(tag, we ? 4 : 3, exp);
    endtask

    int wr0;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy", {126'd0, req_ready, fill_ready}, 128'd0);
        chk("rst_rsp", {95'd0, rsp_valid, rsp_rdata}, 128'd0);
        chk("rst_ctl", {125'd0, sram_csb, sram_web, sram_oeb}, 128'b111);
        chk("rst_a", 128'(sram_a), 128'd0);
        chk("rst_i", sram_i, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", {126'd0, req_ready, fill_ready}, 128'b11);

        // Fill then read
        do_fill("fill5", 6'd5, 128'h00000003_00000002_00000001_00000000);
        do_req("rd5w2", 1'b0, 6'd5, 2'd2, 32'h0, 32'h2);

        // RMW write, stored line check, read back
        wr0 = wr_cnt;
        do_req("wr5w1", 1'b1, 6'd5, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("wr5_cnt", 128'(wr_cnt), 128'(wr0 + 1));
        chk("wr5_a", 128'(last_a), 128'd5);
        chk("wr5_line", last_i, 128'h00000003_00000002_DEADBEEF_00000000);
        do_req("rd5w1", 1'b0, 6'd5, 2'd1, 32'h0, 32'hDEADBEEF);

        // Fill wins a simultaneous request; request taken in next IDLE
        fill_valid = 1'b1;
        fill_index = 6'd0;
        fill_data  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_index  = 6'd5;
        req_word   = 2'd1;
        #1;
        chk("pri_both", {126'd0, fill_ready, req_ready}, 128'b10);
        @(negedge clk);
        fill_valid = 1'b0;
        #1;
        chk("pri_fillwr", {125'd0, sram_csb, sram_web, req_ready}, 128'b000);
        @(negedge clk);
        #1;
        chk("pri_idle", 128'(req_ready), 128'd1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("pri", 3, 32'hDEADBEEF);

        // Top index, no aliasing with index 0
        do_fill("fill63", 6'd63, 128'h6363_6363_6363_6363_6363_6363_6363_6363);
        do_req("wr63w3", 1'b1, 6'd63, 2'd3, 32'h12345678, 32'h12345678);
        chk("wr63_line", last_i, 128'h12345678_63636363_63636363_63636363);
        do_req("rd63w3", 1'b0, 6'd63, 2'd3, 32'h0, 32'h12345678);
        do_req("rd0w0", 1'b0, 6'd0, 2'd0, 32'h0, 32'hA0A0A0A0);

        // Reset during WR_DAT abandons the write
        do_fill("fill7", 6'd7, 128'h73737373_72727272_71717171_70707070);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_index = 6'd7;
        req_word  = 2'd0;
        req_wdata = 32'h0BADF00D;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_wrdat", {125'd0, sram_csb, sram_web, sram_oeb}, 128'b110);
        wr0   = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("rstw_ctl", {125'd0, sram_csb, sram_web, req_ready}, 128'b110);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstw_rdy", 128'(req_ready), 128'd1);
        chk("rstw_nowr", 128'(wr_cnt), 128'(wr0));
        do_req("rd7w0", 1'b0, 6'd7, 2'd0, 32'h0, 32'h70707070);

`ifdef CACHE_DATA_PORT_BYTE_MASK_EN
        do_fill("fill9", 6'd9, 128'h0_0_0_11223344);
        req_be = 4'b0101;
        do_req("be_wr", 1'b1, 6'd9, 2'd0, 32'hAABBCCDD, 32'h11BB33DD);
        req_be = 4'b0000;
        do_req("be_zero", 1'b1, 6'd9, 2'd0, 32'hFFFFFFFF, 32'h11BB33DD);
        req_be = 4'hF;
        do_req("be_rd", 1'b0, 6'd9, 2'd0, 32'h0, 32'h11BB33DD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
